// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing one sdram_ctrl request port among NumPorts requesters.
// Grant -> 1-cycle req pulse -> write hold window or read wait (rd_rdy / timeout) -> per-port response.
module sdram_arbiter #(
  parameter int NumPorts     = 2,
  parameter int AddrWidth    = 22,
  parameter int DataWidth    = 16,
  parameter int WrHoldCycles = 16,
  parameter int RdTimeout    = 64
) (
  input  logic                           i_sys_clk,
  input  logic                           i_rst_n,
  input  logic [NumPorts-1:0]            i_req_valid,
  input  logic [NumPorts-1:0]            i_req_we,
  input  logic [NumPorts*AddrWidth-1:0]  i_req_addr,
  input  logic [NumPorts*DataWidth-1:0]  i_req_data,
  output logic [NumPorts-1:0]            o_req_ready,
  output logic [NumPorts-1:0]            o_rsp_valid,
  output logic [DataWidth-1:0]           o_rsp_data,
  output logic                           o_rsp_err,
  output logic                           o_busy,
  output logic                           o_wr_req,
  output logic [AddrWidth-1:0]           o_wr_addr,
  output logic [DataWidth-1:0]           o_wr_data,
  output logic                           o_rd_req,
  output logic [AddrWidth-1:0]           o_rd_addr,
  input  logic [DataWidth-1:0]           i_rd_data,
  input  logic                           i_rd_rdy
);

  localparam int PW     = $clog2(NumPorts);
  localparam int CntMax = (WrHoldCycles > RdTimeout) ? WrHoldCycles : RdTimeout;
  localparam int CW     = $clog2(CntMax + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, RD_WAIT, WR_HOLD} state_e;

  state_e                 state_q;
  logic [PW-1:0]          ptr_q;
  logic [PW-1:0]          port_q;
  logic                   we_q;
  logic [CW-1:0]          cnt_q;
  logic [NumPorts-1:0]    rsp_valid_q;
  logic [DataWidth-1:0]   rsp_data_q;
  logic                   rsp_err_q;
  logic                   wr_req_q;
  logic                   rd_req_q;
  logic [AddrWidth-1:0]   wr_addr_q;
  logic [DataWidth-1:0]   wr_data_q;
  logic [AddrWidth-1:0]   rd_addr_q;

  logic [PW-1:0]          gnt_idx;
  logic [PW-1:0]          hi_idx;
  logic [PW-1:0]          lo_idx;
  logic                   hi_found;
  logic                   any_vld;
  logic                   sel_we;
  logic [AddrWidth-1:0]   sel_addr;
  logic [DataWidth-1:0]   sel_data;
  logic                   hs;

  // Lowest valid port above the pointer wins; otherwise wrap to the lowest valid port.
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    any_vld  = 1'b0;
    for (int p = NumPorts - 1; p >= 0; p--) begin
      if (i_req_valid[p]) begin
        any_vld = 1'b1;
        lo_idx  = PW'(p);
        if (PW'(p) > ptr_q) begin
          hi_found = 1'b1;
          hi_idx   = PW'(p);
        end
      end
    end
    gnt_idx = hi_found ? hi_idx : lo_idx;
  end

  always_comb begin
    sel_we   = 1'b0;
    sel_addr = '0;
    sel_data = '0;
    for (int p = 0; p < NumPorts; p++) begin
      if (gnt_idx == PW'(p)) begin
        sel_we   = i_req_we[p];
        sel_addr = i_req_addr[p*AddrWidth +: AddrWidth];
        sel_data = i_req_data[p*DataWidth +: DataWidth];
      end
    end
  end

  assign o_req_ready = (state_q == IDLE && any_vld) ? (NumPorts'(1) << gnt_idx) : '0;
  assign hs          = |(o_req_ready & i_req_valid);

  always_ff @(posedge i_sys_clk) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= PW'(NumPorts - 1);
      port_q      <= '0;
      we_q        <= 1'b0;
      cnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      wr_req_q    <= 1'b0;
      rd_req_q    <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      rd_addr_q   <= '0;
    end else begin
      rsp_valid_q <= '0;
      wr_req_q    <= 1'b0;
      rd_req_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (hs) begin
            port_q  <= gnt_idx;
            ptr_q   <= gnt_idx;
            we_q    <= sel_we;
            state_q <= ISSUE;
            if (sel_we) begin
              wr_addr_q <= sel_addr;
              wr_data_q <= sel_data;
              wr_req_q  <= 1'b1;
            end else begin
              rd_addr_q <= sel_addr;
              rd_req_q  <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (we_q) begin
            cnt_q   <= CW'(WrHoldCycles);
            state_q <= WR_HOLD;
          end else begin
            cnt_q   <= CW'(1);
            state_q <= RD_WAIT;
          end
        end
        WR_HOLD: begin
          if (cnt_q == CW'(1)) begin
            state_q     <= IDLE;
            rsp_valid_q <= NumPorts'(1) << port_q;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        RD_WAIT: begin
          // rd_rdy takes precedence over a timeout expiring in the same cycle
          if (i_rd_rdy) begin
            state_q     <= IDLE;
            rsp_valid_q <= NumPorts'(1) << port_q;
            rsp_data_q  <= i_rd_data;
            rsp_err_q   <= 1'b0;
          end else if (cnt_q == CW'(RdTimeout)) begin
            state_q     <= IDLE;
            rsp_valid_q <= NumPorts'(1) << port_q;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_busy      = (state_q != IDLE);
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_data  = rsp_data_q;
  assign o_rsp_err   = rsp_err_q;
  assign o_wr_req    = wr_req_q;
  assign o_wr_addr   = wr_addr_q;
  assign o_wr_data   = wr_data_q;
  assign o_rd_req    = rd_req_q;
  assign o_rd_addr   = rd_addr_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Randomized bench for sdram_arbiter against a cycle-arithmetic reference model.
module tb_sdram_arbiter;
  localparam int NP   = 2;
  localparam int AW   = 22;
  localparam int DW   = 16;
  localparam int WH   = 16;
  localparam int RT   = 64;
  localparam int NCYC = 6000;
  localparam int NSAT = 1500;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NP-1:0]       req_valid, req_we, req_ready, rsp_valid;
  logic [NP*AW-1:0]    req_addr;
  logic [NP*DW-1:0]    req_data;
  logic [DW-1:0]       rsp_data, wr_data, rd_data;
  logic                rsp_err, busy, wr_req, rd_req, rd_rdy;
  logic [AW-1:0]       wr_addr, rd_addr;

  always #5 clk = ~clk;

  sdram_arbiter #(.NumPorts(NP), .AddrWidth(AW), .DataWidth(DW),
                  .WrHoldCycles(WH), .RdTimeout(RT)) dut (
    .i_sys_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid), .i_req_we(req_we), .i_req_addr(req_addr), .i_req_data(req_data),
    .o_req_ready(req_ready), .o_rsp_valid(rsp_valid), .o_rsp_data(rsp_data), .o_rsp_err(rsp_err),
    .o_busy(busy), .o_wr_req(wr_req), .o_wr_addr(wr_addr), .o_wr_data(wr_data),
    .o_rd_req(rd_req), .o_rd_addr(rd_addr), .i_rd_data(rd_data), .i_rd_rdy(rd_rdy)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Model state: one outstanding transaction described by its cycle numbers.
  bit            m_act = 0;
  int            m_port, m_issue, m_resp, m_last = NP - 1;
  bit            m_we, m_err;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata, m_hold = '0;
  int            rdy_at = -1;

  function automatic int first_valid(input logic [NP-1:0] v, input int last);
    for (int k = 1; k <= NP; k++)
      if (v[(last + k) % NP]) return (last + k) % NP;
    return -1;
  endfunction

  initial begin
    logic [NP-1:0] hs_prev, exp_v, exp_rdy, first_req, alt_we;
    bit rst_now, force_both, zchk;
    int n_rst_wr, n_rst_rd, fv, k;

    hs_prev = '0; first_req = '1; alt_we = '1;
    force_both = 0; zchk = 0; n_rst_wr = 0; n_rst_rd = 0;
    rst_n = 1'b0; req_valid = '0; req_we = '0; req_addr = '0; req_data = '0;
    rd_rdy = 1'b0; rd_data = '0;

    repeat (NCYC) begin
      @(posedge clk);
      cyc++;
      #1;
      // ---- drive inputs for this cycle ----
      rst_now = (cyc <= 2);
      if (!rst_now && m_act && cyc > m_issue) begin
        if (m_we && cyc < m_resp && n_rst_wr < 3 && $urandom_range(0, 9) == 0) begin
          rst_now = 1; n_rst_wr++;
        end else if (!m_we && m_resp < 0 && n_rst_rd < 3 && $urandom_range(0, 9) == 0) begin
          rst_now = 1; n_rst_rd++;
        end
      end
      rst_n = !rst_now;

      for (int p = 0; p < NP; p++) begin
        if (cyc <= 2) req_valid[p] = 1'b0;
        else begin
          if (hs_prev[p]) req_valid[p] = 1'b0;
          else if (req_valid[p] && cyc > NSAT && $urandom_range(0, 15) == 0) req_valid[p] = 1'b0;
          if (!req_valid[p] && (cyc <= NSAT || force_both || $urandom_range(0, 3) == 0)) begin
            req_valid[p] = 1'b1;
            req_addr[p*AW +: AW] = AW'($urandom);
            req_data[p*DW +: DW] = DW'($urandom);
            if (first_req[p]) begin
              first_req[p] = 1'b0;
              req_we[p] = (p == 0);
              req_addr[p*AW +: AW] = (p == 0) ? 22'h00012 : 22'h3FFFFF;
              req_data[p*DW +: DW] = 16'h00AB;
            end else if (cyc <= NSAT) begin
              req_we[p] = alt_we[p];
              alt_we[p] = ~alt_we[p];
            end else begin
              req_we[p] = 1'($urandom_range(0, 1));
            end
          end
        end
      end
      force_both = 0;

      rd_rdy  = (cyc == rdy_at);
      if (!rd_rdy && rdy_at < 0 && !(m_act && !m_we) && $urandom_range(0, 15) == 0) rd_rdy = 1'b1;
      rd_data = DW'($urandom);

      // ---- check outputs of this cycle ----
      @(negedge clk);
      exp_v = '0;
      if (m_act && m_resp == cyc) begin
        exp_v  = NP'(1) << m_port;
        m_hold = m_we ? '0 : m_rdata;
        chk("rsp_err", rsp_err, m_we ? 1'b0 : m_err);
        m_act  = 0;
      end
      chk("rsp_valid", rsp_valid, exp_v);
      chk("rsp_data", rsp_data, m_hold);
      chk("wr_req", wr_req, m_act && cyc == m_issue && m_we);
      chk("rd_req", rd_req, m_act && cyc == m_issue && !m_we);
      if (m_act && cyc == m_issue) begin
        if (m_we) begin
          chk("wr_addr", wr_addr, m_addr);
          chk("wr_data", wr_data, m_wdata);
        end else begin
          chk("rd_addr", rd_addr, m_addr);
        end
      end
      chk("busy", busy, m_act && cyc >= m_issue);
      if (zchk) begin
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_rsp_err", rsp_err, 0);
        zchk = 0;
      end

      fv = m_act ? -1 : first_valid(req_valid, m_last);
      exp_rdy = (fv < 0) ? '0 : (NP'(1) << fv);
      chk("req_ready", req_ready, exp_rdy);

      // read completion: first rdy inside the wait window, else timeout at its end
      if (m_act && !m_we && m_resp < 0 && cyc > m_issue) begin
        if (rd_rdy) begin
          m_resp = cyc + 1; m_rdata = rd_data; m_err = 0;
        end else if (cyc == m_issue + RT) begin
          m_resp = cyc + 1; m_rdata = '0; m_err = 1;
        end
      end

      if (rst_n && fv >= 0) begin
        m_act   = 1;
        m_port  = fv;
        m_last  = fv;
        m_issue = cyc + 1;
        m_we    = req_we[fv];
        m_addr  = req_addr[fv*AW +: AW];
        m_wdata = req_data[fv*DW +: DW];
        m_resp  = m_we ? cyc + 2 + WH : -1;
      end
      hs_prev = req_ready & req_valid & {NP{rst_n}};

      if (rdy_at >= 0 && cyc >= rdy_at) rdy_at = -1;
      if (rd_req === 1'b1 && rst_n) begin
        k = $urandom_range(0, 15);
        if (k == 0) rdy_at = -1;
        else if (k == 1) rdy_at = cyc + RT;
        else if (k == 2) rdy_at = cyc + RT + 1;
        else rdy_at = cyc + $urandom_range(1, 8);
      end

      if (!rst_n) begin
        m_act = 0; m_last = NP - 1; rdy_at = -1; m_hold = '0;
        zchk = 1; force_both = 1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
Shares the single sdram_ctrl request interface between NumPorts independent requesters (e.g. UART command FSM, pattern generator/BIST). Grants one access at a time using round-robin. Converts each grant into the single-cycle wr_req/rd_req pulse sdram_ctrl expects. Tracks completion: read via rd_rdy, write via a fixed hold window. Returns a per-port response and flags read timeouts. Sits between the top-level command logic and sdram_ctrl, in the SDRAM clock domain.

Parameters:
NumPorts, 2, number of requesters (>=2)
AddrWidth, 22, SDRAM word address width (matches sdram_ctrl input address)
DataWidth, 16, SDRAM data width
WrHoldCycles, 16, cycles after a write pulse before sdram_ctrl is considered free (>=1)
RdTimeout, 64, max cycles waiting for rd_rdy before an error response (>=1)

Ports:
i_sys_clk  in  1  clock; all logic on posedge
i_rst_n  in  1  synchronous reset, active-low
i_req_valid  in  NumPorts  per-port request valid; held with fields until ready
i_req_we  in  NumPorts  per-port 1=write, 0=read
i_req_addr  in  NumPorts*AddrWidth  per-port address; port p at [p*AddrWidth +: AddrWidth]
i_req_data  in  NumPorts*DataWidth  per-port write data, same packing
o_req_ready  out  NumPorts  one-hot grant; transfer when valid&ready
o_rsp_valid  out  NumPorts  one-cycle pulse on the completing port
o_rsp_data  out  DataWidth  read data (0 for writes/errors); held until next response
o_rsp_err  out  1  qualifies o_rsp_valid: read timed out
o_busy  out  1  high in any state other than IDLE
o_wr_req  out  1  to sdram_ctrl i_wr_req
o_wr_addr  out  AddrWidth  to sdram_ctrl i_wr_addr
o_wr_data  out  DataWidth  to sdram_ctrl i_wr_data
o_rd_req  out  1  to sdram_ctrl i_rd_req
o_rd_addr  out  AddrWidth  to sdram_ctrl i_rd_addr
i_rd_data  in  DataWidth  from sdram_ctrl o_rd_data
i_rd_rdy  in  1  from sdram_ctrl o_rd_rdy

Behaviour:
- Reset (i_rst_n low at a clock edge):
  - state IDLE; RR pointer = NumPorts-1, so port 0 has first priority.
  - All registered outputs 0: o_rsp_valid, o_rsp_data, o_rsp_err, o_wr_req, o_rd_req, addr/data outputs.
- Reset mid-operation: transaction aborted; no response issued; outputs 0 the cycle after the reset edge.
- States: IDLE, ISSUE, RD_WAIT, WR_HOLD.
- IDLE:
  - o_req_ready is combinational: one-hot on the first valid port, searching upward (wrapping) from pointer+1. It is 0 outside IDLE and 0 when no port is valid.
  - On a handshake edge: latch port index, we, addr, data; pointer <= granted port; -> ISSUE.
- ISSUE (exactly 1 cycle):
  - o_wr_req or o_rd_req is high for this cycle only; never both; never high outside ISSUE.
  - o_wr_addr/o_wr_data/o_rd_addr are driven from the latch, registered, valid in ISSUE and held stable until the next grant.
  - Write -> WR_HOLD; read -> RD_WAIT.
- WR_HOLD:
  - Lasts exactly WrHoldCycles cycles (down-counter), then -> IDLE.
  - In the first IDLE cycle: o_rsp_valid[port]=1, o_rsp_err=0, o_rsp_data=0.
- RD_WAIT:
  - Cycle counter starts at 1 on entry.
  - If i_rd_rdy is sampled high: next cycle o_rsp_valid[port]=1, o_rsp_data=i_rd_data, o_rsp_err=0; state IDLE.
  - Else if counter==RdTimeout: next cycle o_rsp_valid[port]=1, o_rsp_err=1, o_rsp_data=0; state IDLE.
  - Rdy and timeout in the same cycle: rdy wins.
- i_rd_rdy outside RD_WAIT is ignored. This covers stale pulses and pulses arriving after a timeout.
- A response cycle is an IDLE cycle, so a new grant may occur in the same cycle.
- Latency, grant at edge T:
  - Req pulse in cycle T+1.
  - Write response in cycle T+2+WrHoldCycles.
  - Read response one cycle after the cycle rd_rdy is sampled.
- Fairness:
  - A port granted once cannot be granted again while any other port holds valid.
  - Max wait = (NumPorts-1) transactions.
- Deasserting valid before ready is permitted; the request is simply dropped.
- Counters are sized $clog2(max+1); no wrap is possible.

Test Plan:
- Single write, port 0, addr 0x00012, data 0x00AB, WrHoldCycles=16 -> o_wr_req pulses 1 cycle with addr 0x00012/data 0x00AB; o_rsp_valid=2'b01 exactly 18 cycles after the grant edge; err=0; o_busy high throughout.
- Single read, port 1, addr 0x3FFFFF; model returns rd_rdy with 0xBEEF 5 cycles after rd_req -> o_rd_req single pulse, o_rsp_valid=2'b10, o_rsp_data=0xBEEF, err=0.
- Both ports valid continuously, alternating write/read -> grants alternate 0,1,0,1 from reset; no double grant; o_wr_req and o_rd_req never high together.
- Read with rd_rdy never asserted, RdTimeout=64 -> o_rsp_err=1, o_rsp_data=0 for the requesting port 65 cycles after rd_req. A late rd_rdy then produces no response; the next request is serviced normally.
- rd_rdy pulse while IDLE or in WR_HOLD -> no o_rsp_valid, no state change.
- Reset asserted in RD_WAIT and in WR_HOLD -> next cycle all outputs 0, state IDLE, no response. First grant after release goes to port 0 when both ports are valid.
